// File: rtl/cap_pkg.sv
// Shared types and width helpers for the cap_frame_stream capture engine.
// Optional drop counter is enabled with the CAP_DROP_COUNT_EN macro.
package cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_e;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 16;

  // Counter width for a range of n values; never below one bit so ROWS=1 still builds.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Synchronous show-ahead FIFO with flush; head is visible the cycle after it is written.
// Output data reads as zero while empty so the stream idles at a known value.
module cap_fifo
  import cap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  localparam int AW = cnt_w(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = (count_q != '0);
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;
  // Fullness is the registered count, so a pop in the same cycle does not make room.
  assign do_wr   = wr_en & ~full & ~flush;
  assign do_rd   = rd_en & valid & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cap_frame_stream.sv
// Frame capture engine: frames a sensor pixel stream, buffers it and emits ready/valid.
// Define CAP_DROP_COUNT_EN to add the saturating DROP_CNT output.
module cap_frame_stream
  import cap_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int NUM_CH     = 1,
  parameter int COLS       = 112,
  parameter int ROWS       = 112,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    SYSCLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    CONT,
  input  logic                    STOP,
  input  logic                    FRAME_START,
  input  logic                    PIX_VALID,
  input  logic [NUM_CH*PIX_W-1:0] PIX_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [NUM_CH*PIX_W-1:0] OUT_DATA,
  output logic                    OUT_LAST,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVERFLOW,
  output logic [FRAME_CNT_W-1:0]  FRAME_CNT
`ifdef CAP_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   DROP_CNT
`endif
);

  localparam int PW    = NUM_CH * PIX_W;
  localparam int COL_W = cnt_w(COLS);
  localparam int ROW_W = cnt_w(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  cap_state_e             state_q, state_d;
  logic                   cont_q, cont_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;
`ifdef CAP_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
`endif

  logic          wr_req, wr_last, flush;
  logic          fifo_full, fifo_valid;
  logic [PW:0]   fifo_rdata;

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    col_d       = col_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    wr_req      = 1'b0;
    wr_last     = 1'b0;
    flush       = 1'b0;
`ifdef CAP_DROP_COUNT_EN
    drop_cnt_d  = drop_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_ARM;
          cont_d      = CONT;
          col_d       = '0;
          row_d       = '0;
          frame_cnt_d = '0;
          overflow_d  = 1'b0;
`ifdef CAP_DROP_COUNT_EN
          drop_cnt_d  = '0;
`endif
        end
      end
      ST_ARM: begin
        if (PIX_VALID && FRAME_START) begin
          state_d = ST_CAPTURE;
          wr_req  = 1'b1;
          col_d   = COL_W'(1);
          row_d   = '0;
        end
      end
      ST_CAPTURE: begin
        if (PIX_VALID) begin
          wr_req = 1'b1;
          // A frame marker mid-frame restarts geometry at this pixel.
          if (FRAME_START) begin
            col_d = COL_W'(1);
            row_d = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              wr_last     = 1'b1;
              row_d       = '0;
              frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
              state_d     = cont_q ? ST_ARM : ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!fifo_valid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a START in the same cycle.
    if (STOP) begin
      state_d     = ST_IDLE;
      flush       = 1'b1;
      wr_req      = 1'b0;
      wr_last     = 1'b0;
      done_d      = 1'b0;
      cont_d      = cont_q;
      frame_cnt_d = frame_cnt_q;
      overflow_d  = overflow_q;
`ifdef CAP_DROP_COUNT_EN
      drop_cnt_d  = drop_cnt_q;
`endif
    end

    if (wr_req && fifo_full) begin
      overflow_d = 1'b1;
`ifdef CAP_DROP_COUNT_EN
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAP_DROP_COUNT_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
`ifdef CAP_DROP_COUNT_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  cap_fifo #(
    .WIDTH(PW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (SYSCLK),
    .rst    (RESET),
    .flush  (flush),
    .wr_en  (wr_req),
    .wr_data({wr_last, PIX_DATA}),
    .full   (fifo_full),
    .rd_en  (OUT_READY),
    .rd_data(fifo_rdata),
    .valid  (fifo_valid)
  );

  assign OUT_VALID = fifo_valid;
  assign OUT_DATA  = fifo_rdata[PW-1:0];
  assign OUT_LAST  = fifo_rdata[PW];
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign OVERFLOW  = overflow_q;
  assign FRAME_CNT = frame_cnt_q;
`ifdef CAP_DROP_COUNT_EN
  assign DROP_CNT  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cap_frame_stream.sv
// Directed bench for cap_frame_stream with a 2x8-bit, 4x2, depth-4 configuration.
// Checks DROP_CNT too when built with CAP_DROP_COUNT_EN.
module tb_cap_frame_stream;

  logic        SYSCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        CONT = 1'b0;
  logic        STOP = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic [15:0] PIX_DATA = 16'h0000;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] OUT_DATA;
  logic        OUT_LAST;
  logic        BUSY;
  logic        DONE;
  logic        OVERFLOW;
  logic [15:0] FRAME_CNT;
`ifdef CAP_DROP_COUNT_EN
  logic [15:0] DROP_CNT;
`endif

  cap_frame_stream #(
    .PIX_W(8), .NUM_CH(2), .COLS(4), .ROWS(2), .FIFO_DEPTH(4)
  ) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .START(START), .CONT(CONT), .STOP(STOP),
    .FRAME_START(FRAME_START), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
    .FRAME_CNT(FRAME_CNT)
`ifdef CAP_DROP_COUNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic        st;
    logic        pv;
    logic        fs;
    logic [15:0] d;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        eb;
    logic        edn;
    logic [15:0] efc;
  } vec_t;

  vec_t        tbl [12];
  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  logic [16:0] got_q [$];

  function automatic logic [15:0] px(input int k);
    return {8'(k), 8'(k - 1)};
  endfunction

  function automatic vec_t mk(input logic st, input logic pv, input logic fs, input logic [15:0] d,
                              input logic ev, input logic [15:0] ed, input logic el,
                              input logic eb, input logic edn, input logic [15:0] efc);
    vec_t v;
    v.st = st; v.pv = pv; v.fs = fs; v.d = d;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.efc = efc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records every handshake that the coming edge will complete, then samples after it.
  task automatic step();
    if (OUT_VALID && OUT_READY) got_q.push_back({OUT_LAST, OUT_DATA});
    @(posedge SYSCLK);
    #1;
    if (DONE) done_cnt++;
  endtask

  task automatic send_pix(input logic [15:0] d, input logic fs);
    PIX_VALID = 1'b1; FRAME_START = fs; PIX_DATA = d;
    step();
    PIX_VALID = 1'b0; FRAME_START = 1'b0;
  endtask

  task automatic start_cap(input logic cont);
    START = 1'b1; CONT = cont;
    step();
    START = 1'b0; CONT = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 30 && BUSY; i++) step();
    chk(name, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(); step();
    RESET = 1'b0;
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic chk_frame(input string name, input int off);
    for (int j = 0; j < 8; j++)
      if (off + j < got_q.size())
        chk($sformatf("%s px%0d", name, j), 32'(got_q[off + j]), {15'd0, (j == 7), px(j + 1)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, px(1),    1'b1, px(1),    1'b0, 1'b1, 1'b0, 16'd0);
    for (int k = 2; k <= 7; k++)
      tbl[k] = mk(1'b0, 1'b1, 1'b0, px(k),   1'b1, px(k),    1'b0, 1'b1, 1'b0, 16'd0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, px(8),    1'b1, px(8),    1'b1, 1'b1, 1'b0, 16'd1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1);

    // Reset values
    do_reset();
    chk("rst out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst out_data", {16'd0, OUT_DATA}, 32'd0);
    chk("rst out_last", {31'd0, OUT_LAST}, 32'd0);
    chk("rst busy", {31'd0, BUSY}, 32'd0);
    chk("rst done", {31'd0, DONE}, 32'd0);
    chk("rst overflow", {31'd0, OVERFLOW}, 32'd0);
    chk("rst frame_cnt", {16'd0, FRAME_CNT}, 32'd0);

    // Single-shot frame, consumer always ready: table-driven cycle by cycle
    OUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      START = tbl[i].st; PIX_VALID = tbl[i].pv; FRAME_START = tbl[i].fs; PIX_DATA = tbl[i].d;
      step();
      START = 1'b0; PIX_VALID = 1'b0; FRAME_START = 1'b0;
      chk($sformatf("t1 vec%0d status", i), {12'd0, OUT_VALID, BUSY, DONE, OVERFLOW, FRAME_CNT},
          {12'd0, tbl[i].ev, tbl[i].eb, tbl[i].edn, 1'b0, tbl[i].efc});
      if (tbl[i].ev)
        chk($sformatf("t1 vec%0d head", i), {15'd0, OUT_LAST, OUT_DATA}, {15'd0, tbl[i].el, tbl[i].ed});
    end
    chk("t1 stream len", got_q.size(), 32'd8);
    chk_frame("t1", 0);
    chk("t1 done count", done_cnt, 32'd1);

    // Consumer stalled: FIFO fills, last four pixels dropped
    do_reset();
    OUT_READY = 1'b0;
    start_cap(1'b0);
    for (int k = 1; k <= 8; k++) send_pix(px(k), k == 1);
    chk("t2 overflow", {31'd0, OVERFLOW}, 32'd1);
    chk("t2 frame_cnt", {16'd0, FRAME_CNT}, 32'd1);
    chk("t2 held head", {15'd0, OUT_VALID, OUT_DATA}, {15'd0, 1'b1, px(1)});
`ifdef CAP_DROP_COUNT_EN
    chk("t2 drop_cnt", {16'd0, DROP_CNT}, 32'd4);
`endif
    step();
    chk("t2 head stable", {15'd0, OUT_VALID, OUT_DATA}, {15'd0, 1'b1, px(1)});
    OUT_READY = 1'b1;
    wait_idle("t2 drained");
    chk("t2 stream len", got_q.size(), 32'd4);
    for (int j = 0; j < 4 && j < got_q.size(); j++)
      chk($sformatf("t2 px%0d", j), 32'(got_q[j]), {16'd0, px(j + 1)});
    chk("t2 done count", done_cnt, 32'd1);

    // Continuous capture, three frames back to back; START clears sticky state
    got_q.delete(); done_cnt = 0;
    start_cap(1'b1);
    chk("t3 start clears", {15'd0, OVERFLOW, FRAME_CNT}, 32'd0);
`ifdef CAP_DROP_COUNT_EN
    chk("t3 drop_cnt cleared", {16'd0, DROP_CNT}, 32'd0);
`endif
    for (int f = 0; f < 3; f++) begin
      for (int k = 1; k <= 8; k++) send_pix(px(k), k == 1);
      chk($sformatf("t3 frame%0d cnt", f), {15'd0, BUSY, FRAME_CNT}, {15'd0, 1'b1, 16'(f + 1)});
    end
    step(); step(); step();
    chk("t3 stream len", got_q.size(), 32'd24);
    for (int f = 0; f < 3; f++) chk_frame($sformatf("t3 f%0d", f), f * 8);
    chk("t3 no done", done_cnt, 32'd0);
    chk("t3 busy", {31'd0, BUSY}, 32'd1);
    STOP = 1'b1; step(); STOP = 1'b0;
    chk("t3 stop idle", {31'd0, BUSY}, 32'd0);

    // ARM discards pixels until the frame marker
    do_reset();
    start_cap(1'b0);
    send_pix(16'hAAAA, 1'b0); send_pix(16'hBBBB, 1'b0); send_pix(16'hCCCC, 1'b0);
    chk("t4 nothing queued", {31'd0, OUT_VALID}, 32'd0);
    for (int k = 1; k <= 8; k++) send_pix(px(k), k == 1);
    wait_idle("t4 drained");
    chk("t4 stream len", got_q.size(), 32'd8);
    chk_frame("t4", 0);
    chk("t4 done/cnt", {15'd0, 1'b0, FRAME_CNT} | 32'(done_cnt << 16), 32'h0001_0001);

    // Mid-row frame marker resynchronises geometry
    do_reset();
    start_cap(1'b0);
    send_pix(16'h1111, 1'b1); send_pix(16'h2222, 1'b0);
    for (int k = 1; k <= 7; k++) send_pix(px(k), k == 1);
    chk("t5 before last", {15'd0, BUSY, FRAME_CNT}, {15'd0, 1'b1, 16'd0});
    send_pix(px(8), 1'b0);
    chk("t5 frame_cnt", {16'd0, FRAME_CNT}, 32'd1);
    wait_idle("t5 drained");
    chk("t5 stream len", got_q.size(), 32'd10);
    if (got_q.size() >= 2) begin
      chk("t5 pre0", 32'(got_q[0]), 32'h0000_1111);
      chk("t5 pre1", 32'(got_q[1]), 32'h0000_2222);
    end
    chk_frame("t5", 2);
    chk("t5 done count", done_cnt, 32'd1);

    // STOP wins over START in IDLE
    START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
    chk("t6 stop beats start", {31'd0, BUSY}, 32'd0);

    // STOP during CAPTURE with three entries queued
    do_reset();
    OUT_READY = 1'b0;
    start_cap(1'b0);
    for (int k = 1; k <= 3; k++) send_pix(px(k), k == 1);
    chk("t6 queued", {15'd0, OUT_VALID, OUT_DATA}, {15'd0, 1'b1, px(1)});
    STOP = 1'b1; step(); STOP = 1'b0;
    chk("t6 after stop", {29'd0, OUT_VALID, BUSY, DONE}, 32'd0);
    OUT_READY = 1'b1;
    step(); step(); step();
    chk("t6 flushed", got_q.size(), 32'd0);
    chk("t6 no done", done_cnt, 32'd0);

    // RESET mid-frame returns every output to its reset value
    OUT_READY = 1'b0;
    start_cap(1'b1);
    for (int k = 1; k <= 8; k++) send_pix(px(k), k == 1);
    send_pix(px(1), 1'b1); send_pix(px(2), 1'b0);
    chk("t7 pre-reset", {13'd0, OUT_VALID, BUSY, OVERFLOW, FRAME_CNT}, {13'd0, 3'b111, 16'd1});
    RESET = 1'b1; step(); RESET = 1'b0;
    chk("t7 reset outputs", {12'd0, OUT_VALID, OUT_LAST, BUSY, DONE, OVERFLOW, OUT_DATA}, 32'd0);
    chk("t7 reset frame_cnt", {16'd0, FRAME_CNT}, 32'd0);
`ifdef CAP_DROP_COUNT_EN
    chk("t7 reset drop_cnt", {16'd0, DROP_CNT}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
